// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master arbiter.
//   apb_state_t : bus phase of the shared master port
//   *_DEF       : default address/data widths
//   PROT_*      : PPROT bit masks
//   clog2_min1  : index/counter width helper, never returns 0
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned PROT_W     = 3;

  localparam logic [PROT_W-1:0] PROT_PRIV      = 3'b001;
  localparam logic [PROT_W-1:0] PROT_NONSECURE = 3'b010;
  localparam logic [PROT_W-1:0] PROT_INSTR     = 3'b100;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter for the APB master port.
//   clk, rst      : clock, synchronous active-high reset
//   req           : pending request per requester
//   advance       : grant was taken this cycle; move the search start past it
//   grant_c       : onehot0 grant (combinational)
//   grant_idx_c   : binary index of grant_c (combinational)
//   grant_valid_c : any request pending (combinational)
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W = clog2_min1(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   grant_idx_c,
  output logic               grant_valid_c
);

  // ptr_q is the first requester searched; 0 after reset.
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // First pending requester at or after ptr_q, wrapping.
  always_comb begin
    int unsigned idx;
    idx           = 0;
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!grant_valid_c && req[IDX_W'(idx)]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = IDX_W'(idx);
      end
    end
    if (grant_valid_c) begin
      grant_c = NUM_REQ'(1) << grant_idx_c;
    end
  end

  // Pointer moves to the requester after the one just served.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid_c) begin
      ptr_d = (grant_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB4 master port among NUM_REQ requesters with round-robin
// arbitration, SETUP/ACCESS sequencing, wait states and a PREADY timeout.
//   PCLK, PRESET     : clock, synchronous active-high reset
//   req_valid/ready  : per-requester handshake (req_ready combinational, onehot0)
//   req_write/addr/wdata/strb/prot : flattened per-requester transfer fields
//   rsp_valid        : one-cycle onehot0 completion pulse
//   rsp_rdata/err    : read data / error of the completing transfer, held
//   PSEL..PPROT      : APB4 request outputs (registered)
//   PRDATA/PREADY/PSLVERR : APB4 completion inputs
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_strb,
  input  logic [NUM_REQ*PROT_W-1:0]     req_prot,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_W-1:0]             PADDR,
  output logic [DATA_W-1:0]             PWDATA,
  output logic [DATA_W/8-1:0]           PSTRB,
  output logic [PROT_W-1:0]             PPROT,
  input  logic [DATA_W-1:0]             PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = clog2_min1(NUM_REQ);
  localparam int unsigned CNT_W  = clog2_min1(TIMEOUT_CYC);

  apb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] lat_idx_q, lat_idx_d;

  logic                 psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0]    paddr_d;
  logic [DATA_W-1:0]    pwdata_d;
  logic [STRB_W-1:0]    pstrb_d;
  logic [PROT_W-1:0]    pprot_d;
  logic [NUM_REQ-1:0]   rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_d;
  logic                 rsp_err_d;

  logic [NUM_REQ-1:0]   grant_c;
  logic [IDX_W-1:0]     grant_idx_c;
  logic                 grant_valid_c;
  logic                 accept_c;
  logic                 timeout_hit_c;

  logic                 sel_write;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [STRB_W-1:0]    sel_strb;
  logic [PROT_W-1:0]    sel_prot;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk           (PCLK),
    .rst           (PRESET),
    .req           (req_valid),
    .advance       (accept_c),
    .grant_c       (grant_c),
    .grant_idx_c   (grant_idx_c),
    .grant_valid_c (grant_valid_c)
  );

  // Accept in IDLE, or back-to-back on the completing ACCESS cycle; never in reset.
  always_comb begin
    accept_c      = !PRESET && grant_valid_c &&
                    ((state_q == IDLE) || ((state_q == ACCESS) && PREADY));
    timeout_hit_c = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    req_ready     = accept_c ? grant_c : '0;
  end

  // Fields of the granted requester.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    sel_prot  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_c == IDX_W'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_strb  = req_strb[i*STRB_W +: STRB_W];
        sel_prot  = req_prot[i*PROT_W +: PROT_W];
      end
    end
  end

  // Next state, bus fields and response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_idx_d   = lat_idx_q;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    pstrb_d     = PSTRB;
    pprot_d     = PPROT;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    case (state_q)
      IDLE: begin
        if (accept_c) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = NUM_REQ'(1) << lat_idx_q;
          rsp_rdata_d = PWRITE ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          state_d     = accept_c ? SETUP : IDLE;
        end else if (timeout_hit_c) begin
          rsp_valid_d = NUM_REQ'(1) << lat_idx_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Reads drive zero strobes and zero write data.
    if (accept_c) begin
      lat_idx_d = grant_idx_c;
      pwrite_d  = sel_write;
      paddr_d   = sel_addr;
      pwdata_d  = sel_write ? sel_wdata : '0;
      pstrb_d   = sel_write ? sel_strb : '0;
      pprot_d   = sel_prot;
    end

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lat_idx_q <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_idx_q <= lat_idx_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      PSTRB     <= pstrb_d;
      PPROT     <= pprot_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: table of single transfers plus
// hand-written back-to-back, timeout and mid-transfer reset sequences.
module tb_apb_master_arbiter;
  import apb_pkg::*;

  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned STRB_W      = 4;
  localparam int unsigned TIMEOUT_CYC = 16;

  logic                        PCLK = 1'b0;
  logic                        PRESET;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_write;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*DATA_W-1:0]   req_wdata;
  logic [NUM_REQ*STRB_W-1:0]   req_strb;
  logic [NUM_REQ*3-1:0]        req_prot;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_err;
  logic                        PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0]           PADDR;
  logic [DATA_W-1:0]           PWDATA;
  logic [STRB_W-1:0]           PSTRB;
  logic [2:0]                  PPROT;
  logic [DATA_W-1:0]           PRDATA  = '0;
  logic                        PREADY  = 1'b0;
  logic                        PSLVERR = 1'b0;

  apb_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          r;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wt;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct { int r; logic [31:0] rdata; bit err; } rsp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot; } bus_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- APB slave model ----------------
  logic [31:0] mem [logic [31:0]];
  int          wait_cfg = 0;
  int          wait_left = 0;
  bit          stuck = 1'b0;
  localparam logic [31:0] ERR_ADDR = 32'hFFFF_FFFC;

  always @(negedge PCLK) begin
    logic [31:0] w;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    if (PSEL && !PENABLE) wait_left = wait_cfg;
    if (PSEL && PENABLE) begin
      if (!stuck && wait_left == 0) begin
        PREADY  = 1'b1;
        PSLVERR = (PADDR == ERR_ADDR);
        w = mem.exists(PADDR) ? mem[PADDR] : 32'h0;
        if (!PWRITE) begin
          PRDATA = w;
        end else if (!PSLVERR) begin
          for (int b = 0; b < 4; b++) if (PSTRB[b]) w[b*8 +: 8] = PWDATA[b*8 +: 8];
          mem[PADDR] = w;
        end
      end else if (wait_left > 0) begin
        wait_left--;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  vec_t pend [NUM_REQ];
  bit   acc_seen [NUM_REQ];
  rsp_t rsp_q [$];
  bus_t bus_q [$];
  bus_t cur_bus;
  int   grant_log [$];
  int   rsp_cyc_log [$];
  int   cyc = 0;
  int   acc_cyc = 0, setup_cyc = 0, access_cyc = 0, rsp_cyc = 0;
  int   run = 0, last_run = 0, psel_falls = 0, rsp_cnt = 0;
  bit   prev_psel = 1'b0, prev_penable = 1'b0;

  always @(posedge PCLK) cyc++;

  always @(negedge PCLK) begin
    rsp_t e;
    bus_t b;
    logic [NUM_REQ-1:0] exp_v;
    #2;
    if (!PRESET) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_seen[i] = 1'b1;
          acc_cyc = cyc;
          grant_log.push_back(i);
          e.r = i; e.rdata = pend[i].exp_rdata; e.err = pend[i].exp_err;
          rsp_q.push_back(e);
          b.wr    = pend[i].wr;
          b.addr  = pend[i].addr;
          b.wdata = pend[i].wr ? pend[i].wdata : 32'h0;
          b.strb  = pend[i].wr ? pend[i].strb : 4'h0;
          b.prot  = pend[i].prot;
          bus_q.push_back(b);
        end
      end
      if (PSEL && !PENABLE) begin
        setup_cyc = cyc;
        n_checks++;
        if (bus_q.size() == 0) begin
          n_fail++;
          $display("FAIL setup_unexpected: got SETUP, expected no transfer (t=%0t)", $time);
        end else begin
          cur_bus = bus_q.pop_front();
        end
      end
      if (PSEL) begin
        check("bus_pwrite", PWRITE, cur_bus.wr);
        check("bus_paddr",  PADDR,  cur_bus.addr);
        check("bus_pwdata", PWDATA, cur_bus.wdata);
        check("bus_pstrb",  PSTRB,  cur_bus.strb);
        check("bus_pprot",  PPROT,  cur_bus.prot);
      end
      if (PENABLE) begin
        if (!prev_penable) begin
          access_cyc = cyc;
          run = 0;
        end
        run++;
        last_run = run;
      end
      if (rsp_valid != '0) begin
        rsp_cyc = cyc;
        rsp_cnt++;
        rsp_cyc_log.push_back(cyc);
        n_checks++;
        if (rsp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid=0x%0h, expected none (t=%0t)", rsp_valid, $time);
        end else begin
          e = rsp_q.pop_front();
          exp_v = '0;
          exp_v[e.r] = 1'b1;
          check("rsp_valid", rsp_valid, exp_v);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err",   rsp_err,   e.err);
        end
      end
    end
    if (prev_psel && !PSEL) psel_falls++;
    prev_psel    = PSEL;
    prev_penable = PENABLE;
  end

  // ---------------- drivers ----------------
  task automatic issue(input vec_t v);
    bit ok;
    ok = 1'b0;
    pend[v.r] = v;
    req_write[v.r]            = v.wr;
    req_addr[v.r*32 +: 32]    = v.addr;
    req_wdata[v.r*32 +: 32]   = v.wdata;
    req_strb[v.r*4 +: 4]      = v.strb;
    req_prot[v.r*3 +: 3]      = v.prot;
    req_valid[v.r]            = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge PCLK);
      if (acc_seen[v.r]) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    acc_seen[v.r]  = 1'b0;
    req_valid[v.r] = 1'b0;
    check("accept_in_time", ok, 1'b1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge PCLK);
      if (rsp_q.size() == 0 && req_valid == '0 && !PSEL) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    check("drain_in_time", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  vec_t tbl [8];
  vec_t v0, v1, v2, v3;
  int   falls0, rsp_cnt0;

  initial begin
    tbl[0] = '{0, 1'b1, 32'h10,        32'hDEADBEEF, 4'hF, 3'b000,    0, 32'h0,        1'b0};
    tbl[1] = '{1, 1'b0, 32'h10,        32'h0,        4'hF, 3'b000,    3, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1, 1'b1, 32'h24,        32'h12345678, 4'h3, PROT_PRIV, 1, 32'h0,        1'b0};
    tbl[3] = '{0, 1'b0, 32'h24,        32'h0,        4'h0, 3'b000,    0, 32'h00005678, 1'b0};
    tbl[4] = '{0, 1'b1, 32'hFFFF_FFFC, 32'hCAFEF00D, 4'hF, 3'b000,    0, 32'h0,        1'b1};
    tbl[5] = '{1, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0, 3'b000,    0, 32'h0,        1'b1};
    tbl[6] = '{1, 1'b1, 32'h30,        32'hA5A5A5A5, 4'hF, PROT_NONSECURE | PROT_INSTR, 2, 32'h0, 1'b0};
    tbl[7] = '{0, 1'b0, 32'h30,        32'h0,        4'hF, PROT_PRIV, 0, 32'hA5A5A5A5, 1'b0};

    // Reset state, with requests pending to show req_ready stays low.
    req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
    req_valid = '1;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_psel",      PSEL,      1'b0);
    check("rst_penable",   PENABLE,   1'b0);
    check("rst_pwrite",    PWRITE,    1'b0);
    check("rst_paddr",     PADDR,     32'h0);
    check("rst_pwdata",    PWDATA,    32'h0);
    check("rst_pstrb",     PSTRB,     4'h0);
    check("rst_pprot",     PPROT,     3'h0);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   rsp_err,   1'b0);
    req_valid = '0;
    PRESET = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;

    // Back-to-back: both requesters busy, zero-wait slave.
    wait_cfg = 0;
    grant_log.delete();
    rsp_cyc_log.delete();
    falls0 = psel_falls;
    v0 = '{0, 1'b1, 32'h40, 32'h11111111, 4'hF, 3'b000, 0, 32'h0,        1'b0};
    v1 = '{1, 1'b1, 32'h44, 32'h22222222, 4'hF, 3'b000, 0, 32'h0,        1'b0};
    v2 = '{0, 1'b0, 32'h44, 32'h0,        4'hF, 3'b000, 0, 32'h22222222, 1'b0};
    v3 = '{1, 1'b0, 32'h40, 32'h0,        4'hF, 3'b000, 0, 32'h11111111, 1'b0};
    fork
      begin issue(v0); issue(v2); end
      begin issue(v1); issue(v3); end
    join
    drain();
    check("b2b_grant_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("b2b_grant0", grant_log[0], 0);
      check("b2b_grant1", grant_log[1], 1);
      check("b2b_grant2", grant_log[2], 0);
      check("b2b_grant3", grant_log[3], 1);
    end
    check("b2b_psel_falls", psel_falls - falls0, 1);
    check("b2b_rsp_count", rsp_cyc_log.size(), 4);
    if (rsp_cyc_log.size() == 4) check("b2b_rsp_span", rsp_cyc_log[3] - rsp_cyc_log[0], 6);

    // Table of single transfers.
    for (int i = 0; i < 8; i++) begin
      wait_cfg = tbl[i].wt;
      issue(tbl[i]);
      drain();
      if (i == 0) begin
        check("lat_setup",  setup_cyc - acc_cyc,  1);
        check("lat_access", access_cyc - acc_cyc, 2);
        check("lat_rsp",    rsp_cyc - acc_cyc,    3);
      end
      if (i == 1) check("wait_access_cycles", last_run, 4);
    end

    // PREADY stuck low: timeout after TIMEOUT_CYC ACCESS cycles.
    stuck = 1'b1;
    issue('{1, 1'b0, 32'h50, 32'h0, 4'h0, 3'b000, 0, 32'h0, 1'b1});
    drain();
    check("timeout_access_cycles", last_run, TIMEOUT_CYC);
    stuck = 1'b0;
    wait_cfg = 0;
    issue('{0, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 0, 32'hA5A5A5A5, 1'b0});
    drain();

    // Reset during ACCESS: abort, no response, pointer back to requester 0.
    wait_cfg = 8;
    issue('{0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 8, 32'hDEADBEEF, 1'b0});
    @(posedge PCLK);
    #1;
    check("pre_reset_penable", PENABLE, 1'b1);
    rsp_cnt0 = rsp_cnt;
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    check("reset_psel",    PSEL,    1'b0);
    check("reset_penable", PENABLE, 1'b0);
    PRESET = 1'b0;
    rsp_q.delete();
    bus_q.delete();
    grant_log.delete();
    repeat (4) @(posedge PCLK);
    #1;
    check("reset_no_rsp", rsp_cnt - rsp_cnt0, 0);
    wait_cfg = 0;
    fork
      issue('{0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 0, 32'hDEADBEEF, 1'b0});
      issue('{1, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 0, 32'hA5A5A5A5, 1'b0});
    join
    drain();
    check("reset_ptr_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
